// File: rtl/cache_refill_ctrl.sv
// Miss refill sequencer: optional dirty-victim write-back, line fetch, then
// the data-array refill strobe and tag update toward the set-associative cache.
module cache_refill_ctrl #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 25
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_miss,
    input  logic [31:0]           i_addr,
    input  logic                  i_victim_dirty,
    input  logic [TAG_BITS-1:0]   i_victim_tag,
    input  logic [127:0]          i_victim_block,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [31:0]           o_mem_addr,
    output logic [127:0]          o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [127:0]          i_mem_rdata,
    output logic                  o_data_from_mem_valid,
    output logic [127:0]          o_data_from_mem,
    output logic                  o_tag_wr,
    output logic [INDEX_BITS-1:0] o_index,
    output logic [TAG_BITS-1:0]   o_tag,
    output logic                  o_busy,
    output logic                  o_refill_done
);

    // state     | meaning
    // S_IDLE    | waiting for a miss
    // S_CAPTURE | victim block/tag/dirty valid from the arrays this cycle
    // S_WB      | dirty victim write-back outstanding
    // S_RD      | line read outstanding
    // S_FILL    | refill strobe and tag write to the arrays
    // S_DONE    | completion pulse, back to idle next
    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WB,
        S_RD,
        S_FILL,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [127:0]          wdata_q, wdata_d;
    logic                  valid_q, valid_d;
    logic [127:0]          data_q, data_d;
    logic                  tag_wr_q, tag_wr_d;
    logic [INDEX_BITS-1:0] index_q, index_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  mem_done;
    logic                  addr_unused;

    // Byte offset within the line never reaches memory.
    assign addr_unused = ^i_addr[3:0];
    assign mem_done    = req_q & i_mem_ack;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        tag_wr_d = 1'b0;
        index_d  = index_q;
        tag_d    = tag_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_miss) begin
                    tag_d   = i_addr[31 -: TAG_BITS];
                    index_d = i_addr[3+INDEX_BITS:4];
                    busy_d  = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                req_d = 1'b1;
                if (i_victim_dirty) begin
                    we_d    = 1'b1;
                    addr_d  = {i_victim_tag, index_q, 4'b0000};
                    wdata_d = i_victim_block;
                    state_d = S_WB;
                end else begin
                    we_d    = 1'b0;
                    addr_d  = {tag_q, index_q, 4'b0000};
                    state_d = S_RD;
                end
            end
            S_WB: begin
                // req stays up: the read follows the write-back without a gap
                if (mem_done) begin
                    we_d    = 1'b0;
                    addr_d  = {tag_q, index_q, 4'b0000};
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (mem_done) begin
                    req_d    = 1'b0;
                    data_d   = i_mem_rdata;
                    valid_d  = 1'b1;
                    tag_wr_d = 1'b1;
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            tag_wr_q <= 1'b0;
            index_q  <= '0;
            tag_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            tag_wr_q <= tag_wr_d;
            index_q  <= index_d;
            tag_q    <= tag_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_mem_req             = req_q;
    assign o_mem_we              = we_q;
    assign o_mem_addr            = addr_q;
    assign o_mem_wdata           = wdata_q;
    assign o_data_from_mem_valid = valid_q;
    assign o_data_from_mem       = data_q;
    assign o_tag_wr              = tag_wr_q;
    assign o_index               = index_q;
    assign o_tag                 = tag_q;
    assign o_busy                = busy_q;
    assign o_refill_done         = done_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based transaction model.
module tb_cache_refill_ctrl;
    localparam int IB = 3;
    localparam int TB = 25;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          i_miss = 1'b0;
    logic [31:0]   i_addr = '0;
    logic          i_victim_dirty = 1'b0;
    logic [TB-1:0] i_victim_tag = '0;
    logic [127:0]  i_victim_block = '0;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [31:0]   o_mem_addr;
    logic [127:0]  o_mem_wdata;
    logic          i_mem_ack = 1'b0;
    logic [127:0]  i_mem_rdata = '0;
    logic          o_data_from_mem_valid;
    logic [127:0]  o_data_from_mem;
    logic          o_tag_wr;
    logic [IB-1:0] o_index;
    logic [TB-1:0] o_tag;
    logic          o_busy;
    logic          o_refill_done;

    cache_refill_ctrl #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
        .clk(clk), .nrst(nrst), .i_miss(i_miss), .i_addr(i_addr),
        .i_victim_dirty(i_victim_dirty), .i_victim_tag(i_victim_tag),
        .i_victim_block(i_victim_block), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata), .o_data_from_mem_valid(o_data_from_mem_valid),
        .o_data_from_mem(o_data_from_mem), .o_tag_wr(o_tag_wr), .o_index(o_index),
        .o_tag(o_tag), .o_busy(o_busy), .o_refill_done(o_refill_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Transaction model: a miss becomes a list of memory requests; the fill
    // follows the last ack, the done pulse follows the fill.
    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } mreq_t;

    mreq_t         reqs[$];
    bit            in_cap, in_fill, in_done;
    logic [31:0]   m_line;
    logic [IB-1:0] e_index;
    logic [TB-1:0] e_tag;
    bit            e_busy, e_req, e_we, e_valid, e_done;
    logic [31:0]   e_addr;
    logic [127:0]  e_wdata, e_data;

    task automatic model_reset();
        reqs.delete();
        in_cap = 0; in_fill = 0; in_done = 0;
        m_line = '0; e_index = '0; e_tag = '0;
        e_busy = 0; e_req = 0; e_we = 0; e_valid = 0; e_done = 0;
        e_addr = '0; e_wdata = '0; e_data = '0;
    endtask

    task automatic model_step();
        bit nx_cap, nx_fill, nx_done;
        mreq_t r;
        nx_cap = 0; nx_fill = 0; nx_done = 0;
        if (!e_busy) begin
            if (i_miss) begin
                m_line  = i_addr & 32'hFFFF_FFF0;
                e_tag   = TB'(i_addr / 128);
                e_index = IB'((i_addr / 16) % 8);
                e_busy  = 1;
                nx_cap  = 1;
            end
        end else if (in_cap) begin
            if (i_victim_dirty) begin
                r.we = 1;
                r.addr = (32'(i_victim_tag) * 128) + (32'(e_index) * 16);
                r.wdata = i_victim_block;
                reqs.push_back(r);
            end
            r.we = 0; r.addr = m_line; r.wdata = '0;
            reqs.push_back(r);
        end else if (reqs.size() > 0) begin
            if (i_mem_ack) begin
                void'(reqs.pop_front());
                if (reqs.size() == 0) begin
                    e_data  = i_mem_rdata;
                    nx_fill = 1;
                end
            end
        end else if (in_fill) begin
            nx_done = 1;
        end else if (in_done) begin
            e_busy = 0;
        end
        in_cap = nx_cap; in_fill = nx_fill; in_done = nx_done;
        e_valid = nx_fill;
        e_done  = nx_done;
        e_req   = (reqs.size() > 0);
        if (e_req) begin
            e_we   = reqs[0].we;
            e_addr = reqs[0].addr;
            if (reqs[0].we) e_wdata = reqs[0].wdata;
        end
    endtask

    initial model_reset();

    always @(negedge clk) begin
        cyc++;
        if (!nrst) model_reset();
        chk("busy", 128'(o_busy), 128'(e_busy));
        chk("req", 128'(o_mem_req), 128'(e_req));
        chk("we", 128'(o_mem_we), 128'(e_we));
        chk("addr", 128'(o_mem_addr), 128'(e_addr));
        chk("wdata", o_mem_wdata, e_wdata);
        chk("fill_valid", 128'(o_data_from_mem_valid), 128'(e_valid));
        chk("tag_wr", 128'(o_tag_wr), 128'(e_valid));
        chk("fill_data", o_data_from_mem, e_data);
        chk("index", 128'(o_index), 128'(e_index));
        chk("tag", 128'(o_tag), 128'(e_tag));
        chk("done", 128'(o_refill_done), 128'(e_done));
        if (nrst) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [31:0] a, input bit dirty,
                              input logic [TB-1:0] vt, input logic [127:0] vb);
        i_miss = 1; i_addr = a; i_victim_dirty = dirty;
        i_victim_tag = vt; i_victim_block = vb;
    endtask

    logic [127:0] rnd;

    initial begin
        repeat (3) tick();
        chk("rst_busy", 128'(o_busy), 128'd0);
        chk("rst_addr", 128'(o_mem_addr), 128'd0);
        nrst = 1;
        repeat (2) tick();

        // clean miss, ack in first req cycle
        start_miss(32'h0000_1234, 0, '0, '0);                  tick(); // c1
        i_miss = 0;
        chk("clean_c1_busy", 128'(o_busy), 128'd1);
        chk("clean_c1_req", 128'(o_mem_req), 128'd0);           tick(); // c2
        chk("clean_c2_req", 128'(o_mem_req), 128'd1);
        chk("clean_c2_we", 128'(o_mem_we), 128'd0);
        chk("clean_c2_addr", 128'(o_mem_addr), 128'h1230);
        i_mem_ack = 1; i_mem_rdata = {16{8'hA5}};              tick(); // c3
        i_mem_ack = 0;
        chk("clean_c3_valid", 128'(o_data_from_mem_valid), 128'd1);
        chk("clean_c3_index", 128'(o_index), 128'd3);
        chk("clean_c3_data", o_data_from_mem, {16{8'hA5}});
        chk("clean_c3_req", 128'(o_mem_req), 128'd0);           tick(); // c4
        chk("clean_c4_done", 128'(o_refill_done), 128'd1);
        chk("clean_c4_busy", 128'(o_busy), 128'd1);             tick(); // c5
        chk("clean_c5_busy", 128'(o_busy), 128'd0);
        repeat (2) tick();

        // dirty miss, write-back ack after 3 cycles
        start_miss(32'h0000_8050, 1, 25'h12, {4{32'hDEAD_BEEF}}); tick(); // c1
        i_miss = 0;                                              tick(); // c2
        for (int k = 0; k < 3; k++) begin
            chk("dirty_wb_req", 128'(o_mem_req), 128'd1);
            chk("dirty_wb_we", 128'(o_mem_we), 128'd1);
            chk("dirty_wb_addr", 128'(o_mem_addr), 128'h950);
            chk("dirty_wb_wdata", o_mem_wdata, {4{32'hDEAD_BEEF}});
            if (k == 2) i_mem_ack = 1;
            tick();
        end
        i_mem_ack = 0;                                           // c5
        chk("dirty_rd_req", 128'(o_mem_req), 128'd1);
        chk("dirty_rd_we", 128'(o_mem_we), 128'd0);
        chk("dirty_rd_addr", 128'(o_mem_addr), 128'h8050);      tick(); // c6
        i_mem_ack = 1; i_mem_rdata = {4{32'h0BAD_CAFE}};       tick(); // c7
        i_mem_ack = 0;
        chk("dirty_fill", 128'(o_data_from_mem_valid), 128'd1);
        chk("dirty_tag", 128'(o_tag), 128'h100);                 tick(); // c8
        chk("dirty_done", 128'(o_refill_done), 128'd1);
        chk("dirty_nofill", 128'(o_data_from_mem_valid), 128'd0);
        repeat (3) tick();

        // stretched write-back ack (10 cycles), then immediate read ack
        start_miss(32'h0001_0040, 1, 25'h1ABC, {4{32'h5A5A_0F0F}}); tick();
        i_miss = 0;                                              tick();
        for (int k = 0; k < 10; k++) begin
            chk("stretch_req", 128'(o_mem_req), 128'd1);
            chk("stretch_we", 128'(o_mem_we), 128'd1);
            chk("stretch_addr", 128'(o_mem_addr), 128'hD5E40);
            chk("stretch_wdata", o_mem_wdata, {4{32'h5A5A_0F0F}});
            if (k == 9) i_mem_ack = 1;
            tick();
        end
        chk("stretch_rd_req", 128'(o_mem_req), 128'd1);
        chk("stretch_rd_addr", 128'(o_mem_addr), 128'h10040);
        i_mem_rdata = {4{32'h1357_9BDF}};                        tick();
        i_mem_ack = 0;
        chk("stretch_req_drop", 128'(o_mem_req), 128'd0);
        chk("stretch_fill", 128'(o_data_from_mem_valid), 128'd1);
        repeat (3) tick();

        // spurious ack in idle, spurious miss during read
        i_mem_ack = 1;                                           tick();
        i_mem_ack = 0;
        chk("spur_idle_busy", 128'(o_busy), 128'd0);
        chk("spur_idle_req", 128'(o_mem_req), 128'd0);           tick();
        start_miss(32'h0000_4560, 0, '0, '0);                   tick();
        i_miss = 0;                                              tick();
        i_miss = 1; i_addr = 32'hFFFF_FFF0;                      tick();
        i_miss = 0; i_mem_ack = 1; i_mem_rdata = {8{16'h2468}};  tick();
        i_mem_ack = 0;
        chk("spur_fill_data", o_data_from_mem, {8{16'h2468}});
        chk("spur_index", 128'(o_index), 128'd6);
        chk("spur_tag", 128'(o_tag), 128'h8A);                   tick();
        tick();
        chk("spur_after_busy", 128'(o_busy), 128'd0);            tick();
        chk("spur_no_new_req", 128'(o_mem_req), 128'd0);
        chk("spur_no_new_busy", 128'(o_busy), 128'd0);
        repeat (2) tick();

        // reset during write-back, late ack ignored, then a normal miss
        start_miss(32'h0000_2000, 1, 25'h7, {4{32'hFACE_FACE}}); tick();
        i_miss = 0;                                              tick();
        chk("rstwb_req_before", 128'(o_mem_req), 128'd1);        tick();
        nrst = 0;
        #1;
        chk("rstwb_req", 128'(o_mem_req), 128'd0);
        chk("rstwb_busy", 128'(o_busy), 128'd0);
        chk("rstwb_addr", 128'(o_mem_addr), 128'd0);
        chk("rstwb_wdata", o_mem_wdata, 128'd0);                 tick();
        nrst = 1; i_mem_ack = 1;                                 tick();
        i_mem_ack = 0;
        chk("rstwb_late_ack_busy", 128'(o_busy), 128'd0);
        chk("rstwb_late_ack_req", 128'(o_mem_req), 128'd0);      tick();
        start_miss(32'h0000_3370, 0, '0, '0);                   tick();
        i_miss = 0;                                              tick();
        chk("rstwb_next_addr", 128'(o_mem_addr), 128'h3370);
        i_mem_ack = 1; i_mem_rdata = {4{32'h7777_1111}};       tick();
        i_mem_ack = 0;
        chk("rstwb_next_fill", 128'(o_data_from_mem_valid), 128'd1);
        chk("rstwb_next_index", 128'(o_index), 128'd7);          tick();
        chk("rstwb_next_done", 128'(o_refill_done), 128'd1);
        repeat (2) tick();

        // back-to-back misses with i_miss held across DONE
        start_miss(32'h0000_0100, 0, '0, '0);                   tick(); // c1
        tick();                                                          // c2
        i_mem_ack = 1; i_mem_rdata = {4{32'hAAAA_0001}};       tick(); // c3
        i_mem_ack = 0;                                           tick(); // c4
        chk("b2b_done1", 128'(o_refill_done), 128'd1);
        i_addr = 32'h0000_0ABC;                                  tick(); // c5
        chk("b2b_idle_busy", 128'(o_busy), 128'd0);              tick(); // c6
        i_miss = 0;
        chk("b2b_second_busy", 128'(o_busy), 128'd1);
        chk("b2b_second_tag", 128'(o_tag), 128'h15);             tick(); // c7
        chk("b2b_second_addr", 128'(o_mem_addr), 128'hAB0);
        i_mem_ack = 1; i_mem_rdata = {4{32'hBBBB_0002}};       tick(); // c8
        i_mem_ack = 0;                                           tick(); // c9
        chk("b2b_done2", 128'(o_refill_done), 128'd1);
        repeat (3) tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            i_miss         = ($urandom % 4 == 0);
            i_addr         = $urandom;
            i_victim_dirty = $urandom % 2;
            i_victim_tag   = TB'($urandom);
            rnd            = {$urandom, $urandom, $urandom, $urandom};
            i_victim_block = rnd;
            i_mem_ack      = ($urandom % 3 == 0);
            i_mem_rdata    = {$urandom, $urandom, $urandom, $urandom};
            nrst           = (i != 1500);
            tick();
        end
        nrst = 1; i_miss = 0; i_mem_ack = 0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Sequences line replacement for the set-associative data cache on a miss.
- Optionally writes back the dirty LRU victim block, fetches the missing 128-bit line from memory, then drives the data array's refill write and the tag array update.
- Sits between the cache controller (miss/stall side) and the external memory bus.
- Owns the data array's `i_data_from_mem_valid` / `i_data_from_mem` inputs and consumes its registered victim block output.

Parameters:
- INDEX_BITS, 3, set index width; must match the data and tag arrays.
- TAG_BITS, 25, tag width; equals 32 - INDEX_BITS - 4 (16-byte lines).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- i_miss  in  1  miss request from cache controller; sampled only in IDLE.
- i_addr  in  32  missing byte address; captured when the miss is accepted.
- i_victim_dirty  in  1  LRU victim line is valid and dirty; sampled in CAPTURE.
- i_victim_tag  in  TAG_BITS  victim tag; sampled in CAPTURE.
- i_victim_block  in  128  data array block-to-memory output (registered, valid one cycle after the index/LRU inputs are stable); sampled in CAPTURE.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  1 = write-back, 0 = line read.
- o_mem_addr  out  32  line-aligned address, bits [3:0] = 0.
- o_mem_wdata  out  128  write-back data.
- i_mem_ack  in  1  memory completion; for reads, i_mem_rdata is valid in the same cycle.
- i_mem_rdata  in  128  fetched line.
- o_data_from_mem_valid  out  1  refill write strobe to data array.
- o_data_from_mem  out  128  refill line to data array.
- o_tag_wr  out  1  tag array update strobe; asserted with the refill strobe.
- o_index  out  INDEX_BITS  captured index, driven to the arrays during refill.
- o_tag  out  TAG_BITS  captured tag, for the tag array write.
- o_busy  out  1  high in every state except IDLE; the cache controller stalls the core on it.
- o_refill_done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (async, nrst=0): state = IDLE. All outputs 0, including the address/data registers. Applies mid-transaction: any outstanding request is abandoned, and a late i_mem_ack after reset release is ignored in IDLE.
- Registers: all outputs are registered. Captured address and tag remain stable from acceptance until DONE.
- IDLE: when i_miss=1, latch i_addr (tag = [31:32-TAG_BITS], index = [3+INDEX_BITS:4]) and go to CAPTURE.
- CAPTURE (1 cycle): latch i_victim_block, i_victim_tag and i_victim_dirty.
  - If dirty, go to WB with o_mem_req=1, o_mem_we=1, o_mem_addr={victim_tag, index, 4'b0}, o_mem_wdata=victim block.
  - Otherwise go to RD with o_mem_req=1, o_mem_we=0, o_mem_addr={tag, index, 4'b0}.
- Handshake rules:
  - req, we, addr and wdata are held constant until i_mem_ack is sampled high while req=1.
  - req drops the cycle after ack.
  - ack is permitted in the first cycle req is high.
  - ack while req=0 is ignored.
  - No timeout; the controller waits indefinitely.
- WB: on ack, go to RD. req stays high with we=0 and the miss line address; it may remain asserted continuously across the transition.
- RD: on ack, register i_mem_rdata into o_data_from_mem, drop req, and go to FILL.
- FILL (1 cycle): o_data_from_mem_valid=1, o_tag_wr=1, o_index/o_tag driven. Next state is DONE.
- DONE (1 cycle): o_refill_done=1, o_data_from_mem_valid=0. Next state is IDLE; o_busy drops entering IDLE.
- Latency, clean miss with ack in the first req cycle: miss accepted at cycle 0, req visible cycle 2, FILL cycle 3, done pulse cycle 4.
- Dirty miss adds one cycle per WB ack wait, minimum 1.
- i_miss while busy is ignored. i_miss held high in the IDLE cycle after DONE starts a new miss; the cache controller deasserts it on o_refill_done.
- o_data_from_mem holds its last value outside FILL; only the strobe qualifies it.

Test Plan:
- Clean miss: i_addr=0x0000_1234, dirty=0, ack on first req cycle with rdata=0xA5…A5 -> one read with addr 0x0000_1230; FILL at cycle 3 with index=3 and valid=1; done pulse at cycle 4; busy high for cycles 1-4.
- Dirty miss: victim_tag=0x12, index=5, block=0xDEAD…, WB ack after 3 cycles -> write addr {0x12,5,0} with wdata=0xDEAD…; then read of the miss line; exactly one FILL strobe and one done pulse.
- Stretched ack: ack arrives 10 cycles after req -> addr, we and wdata stable for all 10 cycles; req drops the cycle after ack.
- Spurious signals: ack pulsed in IDLE and i_miss pulsed during RD -> no state change and no extra memory request.
- Reset mid-WB: nrst low for 1 cycle while req=1 -> all outputs 0 immediately; a following ack is ignored; the next miss completes normally.
- Back-to-back misses: i_miss held high across DONE -> second miss accepted in the IDLE cycle following DONE with the new address; two distinct done pulses.
